uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter n, default 8: width of the baud divisor input BR.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 BR  input  n  bit period in clk cycles; sampled only at frame acceptance.
REQ-005 DATA_Tx  input  8  byte to transmit; sampled only at frame acceptance.
REQ-006 start  input  1  transmit request; level-sampled each cycle.
REQ-007 Tx  output  1  serial line; idle high.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 eop  output  1  one-cycle pulse marking end of frame.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-011 Each bit SHALL last Bp clk cycles, where Bp = latched BR; BR values 0 and 1 SHALL be treated as Bp = 2.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; the encoding SHALL be registered.
REQ-013 In IDLE with start=1 at a rising edge: DATA_Tx and BR latched, state -> START, Tx=0 and busy=1 from that edge (1-cycle latency).
REQ-014 START: after Bp cycles -> DATA, Tx = latched bit 0.
REQ-015 DATA: shift right every Bp cycles; a 3-bit bit index SHALL count 0..7; after bit 7 has held for Bp cycles -> STOP, Tx=1.
REQ-016 STOP: after Bp cycles -> IDLE; eop=1 for exactly the last clk cycle of STOP; busy SHALL drop at the same edge IDLE is entered.
REQ-017 Total frame duration SHALL be exactly 10*Bp cycles from acceptance edge to the IDLE-return edge.
REQ-018 start asserted while busy=1 SHALL be ignored (no queuing); start held high continuously SHALL begin a new frame on the first cycle in IDLE (back-to-back frames with no idle gap).
REQ-019 Changes to DATA_Tx or BR during a frame SHALL NOT affect the frame in progress.
REQ-020 Tx SHALL be driven from a flip-flop (glitch-free output).
REQ-021 Bit-period counter SHALL count 0..Bp-1 and wrap; it SHALL be cleared on acceptance so the first bit is a full Bp cycles.

Reset
REQ-022 rst=0 SHALL asynchronously force state IDLE, Tx=1, busy=0, eop=0, counters and data/BR latches to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; after release no partial frame resumes and the block SHALL wait for a new start.
REQ-024 The first frame after reset release SHALL be accepted no earlier than the first rising edge with rst=1.

Structure
REQ-025 A shared package SHALL hold the FSM state encodings, the frame length constant (10), and the data width constant (8).
REQ-026 One sub-module uart_tx_baud (bit-period counter with clear, Bp input, one-cycle tick output) SHALL be instantiated; the FSM and shift register SHALL be in uart_tx.

Verification
REQ-027 BR=4, DATA_Tx=0x55, 1-cycle start pulse -> Tx = 0,1,0,1,0,1,0,1,0,1, each 4 cycles; eop pulse in cycle 40; busy high for cycles 1..40.
REQ-028 BR=3, DATA_Tx=0xA3, start held high for 2 frames -> two contiguous 30-cycle frames, Tx pattern 0,1,1,0,0,0,1,0,1,1 repeated, no idle cycle between them, two eop pulses spaced 30 cycles apart.
REQ-029 BR=1 and BR=0, DATA_Tx=0xFF -> each bit lasts 2 cycles; frame is 20 cycles; Tx low only during cycles 1-2.
REQ-030 Mid-frame, after DATA starts, change DATA_Tx to 0x00 and BR to 9, then pulse start -> the original frame completes unchanged, the second start is ignored, and busy stays continuous.
REQ-031 Assert rst during data bit 4 -> Tx=1 and busy=0 immediately without waiting for a clock; no eop; after release, start with 0x0F sends a clean full frame.
REQ-032 Loopback into the existing UART receiver with the same BR, 16 random bytes -> received DATA_Rx matches each byte, with one receiver interrupt per transmitter eop.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: FSM state encodings and frame geometry.
package uart_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Start bit + data bits + stop bit
  localparam int FRAME_BITS = 10;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period counter: counts 0..bp-1 and wraps, pulsing tick during the last
// cycle of each bit period. clear restarts the period so a new frame's first
// bit gets a full bp cycles.
module uart_tx_baud
  import uart_tx_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [N-1:0] bp,
  output logic         tick
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] cnt;

  assign tick = (cnt == (bp - ONE));

  // Advance the period counter, wrapping at bp-1 or restarting on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
// Each bit lasts Bp clock cycles, where Bp is the divisor latched at frame
// acceptance (values below 2 are stretched to 2).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int n = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [n-1:0]      BR,
  input  logic [DATA_W-1:0] DATA_Tx,
  input  logic              start,
  output logic              Tx,
  output logic              busy,
  output logic              eop
);

  localparam logic [n-1:0] TWO      = n'(2);
  // Frame is start + DATA_W data + stop, so the final data bit index is FRAME_BITS-3.
  localparam logic [2:0]   LAST_BIT = 3'(FRAME_BITS - 3);

  logic [1:0]        state;
  logic [DATA_W-1:0] data_q;
  logic [n-1:0]      br_q;
  logic [n-1:0]      bp_eff;
  logic [2:0]        bit_idx;
  logic              tick;
  logic              accept;

  // Divisors 0 and 1 cannot produce a usable period, so they run as 2.
  assign bp_eff = (br_q < TWO) ? TWO : br_q;

  // A frame is accepted from IDLE, or on the final edge of STOP so that a
  // continuously held start produces back-to-back frames with no idle gap.
  assign accept = start && ((state == ST_IDLE) || ((state == ST_STOP) && tick));

  assign busy = (state != ST_IDLE);
  assign eop  = (state == ST_STOP) && tick;

  uart_tx_baud #(
    .N(n)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .bp   (bp_eff),
    .tick (tick)
  );

  // Frame sequencer: latches the request, then steps start/data/stop on each bit tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      Tx      <= 1'b1;
      data_q  <= '0;
      br_q    <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      state   <= ST_START;
      Tx      <= 1'b0;
      data_q  <= DATA_Tx;
      br_q    <= BR;
      bit_idx <= '0;
    end else if (tick) begin
      case (state)
        ST_START: begin
          state   <= ST_DATA;
          Tx      <= data_q[0];
          bit_idx <= '0;
        end
        ST_DATA: begin
          if (bit_idx == LAST_BIT) begin
            state <= ST_STOP;
            Tx    <= 1'b1;
          end else begin
            Tx      <= data_q[1];
            data_q  <= data_q >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          state <= ST_IDLE;
          Tx    <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a frame-level timing model checked every cycle, plus
// directed scenarios with hand-computed waveforms and a serial decoder loopback.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] BR;
  logic [7:0] DATA_Tx;
  logic       start;
  logic       Tx;
  logic       busy;
  logic       eop;

  int checks = 0;
  int passes = 0;

  logic tx_log   [0:127];
  logic busy_log [0:127];
  logic eop_log  [0:127];

  // Model state: frame in flight, cycles elapsed since acceptance, latched byte and period.
  logic       m_active = 1'b0;
  int         m_k      = 0;
  int         m_bp     = 2;
  logic [7:0] m_data   = 8'h00;

  uart_tx #(
    .n(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .BR     (BR),
    .DATA_Tx(DATA_Tx),
    .start  (start),
    .Tx     (Tx),
    .busy   (busy),
    .eop    (eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic modelTx();
    int pos;
    if (!m_active) return 1'b1;
    pos = (m_k - 1) / m_bp;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_data[pos-1];
    return 1'b1;
  endfunction

  // Frame-level model: a frame lasts 10*Bp cycles; a new one may start when idle or on its last edge.
  always @(posedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      m_k      = 0;
    end else begin
      logic done_now;
      done_now = m_active && (m_k == 10 * m_bp);
      if ((!m_active || done_now) && start) begin
        m_active = 1'b1;
        m_k      = 1;
        m_data   = DATA_Tx;
        m_bp     = (BR < 8'd2) ? 2 : int'(BR);
      end else if (done_now) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_k++;
      end
    end
  end

  // Compare DUT outputs against the model shortly after every rising edge.
  always begin
    @(posedge clk);
    #2;
    checkOutput("model_tx",   int'(Tx),   int'(modelTx()));
    checkOutput("model_busy", int'(busy), int'(m_active));
    checkOutput("model_eop",  int'(eop),  int'(m_active && (m_k == 10 * m_bp)));
  end

  task automatic sampleCycle(input int k);
    @(negedge clk);
    tx_log[k]   = Tx;
    busy_log[k] = busy;
    eop_log[k]  = eop;
  endtask

  // Request one frame and log outputs for cycles 1..ncycles; start drops after cycle 'hold'.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] br, input int ncycles, input int hold);
    @(negedge clk);
    DATA_Tx = d;
    BR      = br;
    start   = 1'b1;
    for (int k = 1; k <= ncycles; k++) begin
      sampleCycle(k);
      if (k == hold) start = 1'b0;
    end
  endtask

  function automatic int eopCount(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (eop_log[k]) c++;
    return c;
  endfunction

  function automatic int busyCount(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (busy_log[k]) c++;
    return c;
  endfunction

  initial begin
    logic [9:0] pat;
    logic [7:0] d;
    logic [7:0] br;
    logic [7:0] rx;
    int         bp;

    rst     = 1'b0;
    start   = 1'b0;
    BR      = 8'd0;
    DATA_Tx = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_tx",   int'(Tx),   1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_eop",  int'(eop),  0);
    rst = 1'b1;
    @(negedge clk);

    // BR=4, 0x55, single-cycle start pulse
    applyStimulus(8'h55, 8'd4, 44, 1);
    for (int b = 0; b < 10; b++) checkOutput($sformatf("f55_bit%0d", b), int'(tx_log[b*4+2]), b % 2);
    checkOutput("f55_busy_c1",  int'(busy_log[1]),  1);
    checkOutput("f55_busy_c40", int'(busy_log[40]), 1);
    checkOutput("f55_busy_c41", int'(busy_log[41]), 0);
    checkOutput("f55_eop_c40",  int'(eop_log[40]),  1);
    checkOutput("f55_eop_cnt",  eopCount(1, 44),    1);
    checkOutput("f55_busy_cnt", busyCount(1, 44),   40);

    // BR=3, 0xA3, start held for two back-to-back frames
    pat = 10'b11_0100_0110; // bit b = Tx of frame bit b: 0,1,1,0,0,0,1,0,1,1
    applyStimulus(8'hA3, 8'd3, 64, 31);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 10; b++)
        checkOutput($sformatf("fA3_f%0d_bit%0d", f, b), int'(tx_log[f*30 + b*3 + 2]), int'(pat[b]));
    checkOutput("fA3_busy_cnt", busyCount(1, 60), 60);
    checkOutput("fA3_busy_c61", int'(busy_log[61]), 0);
    checkOutput("fA3_eop_c30",  int'(eop_log[30]), 1);
    checkOutput("fA3_eop_c60",  int'(eop_log[60]), 1);
    checkOutput("fA3_eop_cnt",  eopCount(1, 64), 2);
    checkOutput("fA3_tx_c31",   int'(tx_log[31]), 0);

    // BR=1 and BR=0 both behave as a 2-cycle bit
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8'hFF, (i == 0) ? 8'd1 : 8'd0, 23, 1);
      checkOutput($sformatf("fFF_br%0d_tx_c1", 1 - i), int'(tx_log[1]), 0);
      checkOutput($sformatf("fFF_br%0d_tx_c2", 1 - i), int'(tx_log[2]), 0);
      checkOutput($sformatf("fFF_br%0d_tx_c3", 1 - i), int'(tx_log[3]), 1);
      checkOutput($sformatf("fFF_br%0d_eop_c20", 1 - i), int'(eop_log[20]), 1);
      checkOutput($sformatf("fFF_br%0d_busy_cnt", 1 - i), busyCount(1, 23), 20);
    end

    // Mid-frame input changes and an extra start pulse must not disturb the frame
    @(negedge clk);
    DATA_Tx = 8'h3C;
    BR      = 8'd5;
    start   = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      sampleCycle(k);
      if (k == 1) start = 1'b0;
      if (k == 8) begin
        DATA_Tx = 8'h00;
        BR      = 8'd9;
      end
      if (k == 20) start = 1'b1;
      if (k == 21) start = 1'b0;
    end
    checkOutput("mid_tx_c28",   int'(tx_log[28]), 1);
    checkOutput("mid_tx_c38",   int'(tx_log[38]), 0);
    checkOutput("mid_busy_cnt", busyCount(1, 50), 50);
    checkOutput("mid_busy_c51", int'(busy_log[51]), 0);
    checkOutput("mid_busy_c58", int'(busy_log[58]), 0);
    checkOutput("mid_eop_c50",  int'(eop_log[50]), 1);
    checkOutput("mid_eop_cnt",  eopCount(1, 60), 1);

    // Reset during data bit 4 aborts the frame immediately
    applyStimulus(8'h00, 8'd4, 22, 1);
    checkOutput("rst_pre_tx",   int'(tx_log[22]),   0);
    checkOutput("rst_pre_busy", int'(busy_log[22]), 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_async_tx",   int'(Tx),   1);
    checkOutput("rst_async_busy", int'(busy), 0);
    checkOutput("rst_async_eop",  int'(eop),  0);
    for (int k = 1; k <= 3; k++) sampleCycle(k);
    checkOutput("rst_hold_eop_cnt", eopCount(1, 3), 0);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) sampleCycle(k);
    checkOutput("rst_after_busy_cnt", busyCount(1, 4), 0);
    checkOutput("rst_after_eop_cnt",  eopCount(1, 4),  0);
    pat = 10'b10_0001_1110; // 0, 1,1,1,1, 0,0,0,0, 1
    applyStimulus(8'h0F, 8'd4, 42, 1);
    for (int b = 0; b < 10; b++) checkOutput($sformatf("f0F_bit%0d", b), int'(tx_log[b*4+2]), int'(pat[b]));
    checkOutput("f0F_eop_c40", int'(eop_log[40]), 1);
    checkOutput("f0F_eop_cnt", eopCount(1, 42), 1);

    // Loopback: decode the serial line mid-bit and compare with the byte sent
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      br = 8'($urandom_range(0, 6));
      bp = (br < 8'd2) ? 2 : int'(br);
      applyStimulus(d, br, 10 * bp + 2, 1);
      for (int b = 0; b < 8; b++) rx[b] = tx_log[(b + 1) * bp + bp / 2 + 1];
      checkOutput($sformatf("loop%0d_start", i), int'(tx_log[bp / 2 + 1]), 0);
      checkOutput($sformatf("loop%0d_stop", i),  int'(tx_log[9 * bp + bp / 2 + 1]), 1);
      checkOutput($sformatf("loop%0d_data", i),  int'(rx), int'(d));
      checkOutput($sformatf("loop%0d_eop_cnt", i), eopCount(1, 10 * bp + 2), 1);
      checkOutput($sformatf("loop%0d_eop_pos", i), int'(eop_log[10 * bp]), 1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
